// File: rtl/fft_result_reader.sv
// fft_result_reader
//   Streams one FFT result frame out of the result RAM whenever the engine's
//   completion flag rises. Reads are issued in natural output order.
//   BITREV maps the output index to a bit-reversed RAM address.
//   Returned words pass through a 2-entry skid FIFO. Each entry is tagged
//   with its output index, so downstream back-pressure never loses a beat.
//
// Ports
//   clk, rst_n          system clock / synchronous active-low reset
//   fft_ok              engine completion level; its rising edge starts a readout
//   ram_rd_en/ram_addr  RAM read request
//   ram_rdata           RAM read data, one cycle after ram_rd_en
//   m_valid/m_ready     output beat handshake
//   m_data/m_index      result word and its natural-order bin index
//   m_last              marks bin N-1
//   busy                readout in progress (engine must not write RAM)
//   done                one-cycle pulse after the last beat is accepted
module fft_result_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fft_ok,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  logic [1:0]        state_q, state_d;
  logic              ok_q;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              infl_q;
  logic [ADDR_W-1:0] tag_q;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [ADDR_W-1:0] fifo_idx_q  [2];
  logic              rp_q, wp_q;
  logic [1:0]        cnt_q;

  logic              trigger, pop, push, rd_en, head_last;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] k_rev;

  assign trigger   = (state_q == S_IDLE) && fft_ok && !ok_q;
  assign push      = infl_q;
  assign pop       = (cnt_q != 2'd0) && m_ready;
  assign head_last = (fifo_idx_q[rp_q] == LAST_IDX);

  // Slots committed once this cycle's pop is accounted for. A read is issued
  // only if its word is guaranteed a FIFO slot when it returns.
  assign occ   = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
  assign rd_en = (state_q == S_READ) && (occ < 3'd2);

  always_comb begin
    k_rev = '0;
    for (int i = 0; i < ADDR_W; i++) k_rev[i] = k_q[ADDR_W-1-i];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_READ;
          k_d     = '0;
        end
      end
      S_READ: begin
        if (rd_en) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      // Reset high so a flag already high through reset is not taken as an edge.
      ok_q    <= 1'b1;
      k_q     <= '0;
      infl_q  <= 1'b0;
      tag_q   <= '0;
      done_q  <= 1'b0;
      rp_q    <= 1'b0;
      wp_q    <= 1'b0;
      cnt_q   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ok_q    <= fft_ok;
      k_q     <= k_d;
      infl_q  <= rd_en;
      tag_q   <= k_q;
      done_q  <= done_d;
      if (push) begin
        fifo_data_q[wp_q] <= ram_rdata;
        fifo_idx_q[wp_q]  <= tag_q;
        wp_q              <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign ram_rd_en = rd_en;
  assign ram_addr  = (BITREV != 0) ? k_rev : k_q;
  assign m_valid   = (cnt_q != 2'd0);
  assign m_data    = m_valid ? fifo_data_q[rp_q] : '0;
  assign m_index   = m_valid ? fifo_idx_q[rp_q]  : '0;
  assign m_last    = m_valid && head_last;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_fft_result_reader.sv
module tb_fft_result_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, fft_ok, m_ready;
  logic [1:0]         rd_en, m_valid, m_last, busy, done;
  logic [1:0][AW-1:0] addr, m_index;
  logic [1:0][DW-1:0] rdata, m_data;

  int vecs = 0;
  int errs = 0;

  // Instance 0: natural order, instance 1: bit-reversed addressing.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft_result_reader #(.ADDR_W(AW), .DATA_W(DW), .BITREV(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .fft_ok(fft_ok),
      .ram_rd_en(rd_en[g]), .ram_addr(addr[g]), .ram_rdata(rdata[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready), .m_data(m_data[g]),
      .m_index(m_index[g]), .m_last(m_last[g]), .busy(busy[g]), .done(done[g])
    );
  end

  function automatic logic [DW-1:0] ramw(input logic [AW-1:0] a);
    logic [15:0] i;
    i = 16'(a);
    return {i, ~i};
  endfunction

  function automatic logic [AW-1:0] rev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] expw(input int g, input int idx);
    logic [AW-1:0] a;
    a = AW'(idx);
    return ramw((g != 0) ? rev(a) : a);
  endfunction

  // RAM model: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      rdata[g] <= rd_en[g] ? ramw(addr[g]) : 32'hDEADBEEF;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fft_ok = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      vecs++;
      if ({rd_en[g], m_valid[g], m_last[g], busy[g], done[g]} !== 5'b0 ||
          addr[g] !== '0 || m_data[g] !== '0 || m_index[g] !== '0) begin
        errs++;
        $display("FAIL reset_outputs inst%0d: got rd=%b v=%b l=%b b=%b d=%b a=%0h dat=%0h idx=%0h, expected all zero",
                 g, rd_en[g], m_valid[g], m_last[g], busy[g], done[g], addr[g], m_data[g], m_index[g]);
      end
    end
    // fft_ok held high across reset release must not start a readout
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        vecs++;
        if (busy[g] !== 1'b0 || rd_en[g] !== 1'b0) begin
          errs++;
          $display("FAIL ok_high_thru_reset inst%0d: got busy=%b rd=%b, expected 0 0", g, busy[g], rd_en[g]);
        end
      end
    end
    fft_ok = 1'b0;
    tick();
  endtask

  // Full frame with m_ready=1: exact cycle timing, order and data for both instances.
  task automatic test_stream();
    logic exp_v;
    int idx;
    fft_ok = 1'b1; m_ready = 1'b1;
    for (int cyc = 1; cyc <= 1030; cyc++) begin
      tick();
      if (cyc == 5) fft_ok = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (cyc == 1) begin
          vecs++;
          if (rd_en[g] !== 1'b1 || addr[g] !== '0) begin
            errs++;
            $display("FAIL first_read inst%0d: got rd=%b addr=%0h, expected 1 0", g, rd_en[g], addr[g]);
          end
        end
        exp_v = (cyc >= 3 && cyc <= N + 2);
        vecs++;
        if (m_valid[g] !== exp_v) begin
          errs++;
          $display("FAIL stream_valid inst%0d cyc%0d: got %b expected %b", g, cyc, m_valid[g], exp_v);
        end
        if (exp_v) begin
          idx = cyc - 3;
          vecs++;
          if (m_index[g] !== AW'(idx) || m_data[g] !== expw(g, idx) || m_last[g] !== (idx == N - 1)) begin
            errs++;
            $display("FAIL stream_beat inst%0d: got idx=%0d data=%0h last=%b, expected idx=%0d data=%0h last=%b",
                     g, m_index[g], m_data[g], m_last[g], idx, expw(g, idx), (idx == N - 1));
          end
          if (g == 1 && (idx == 1 || idx == 2 || idx == 1023)) begin
            vecs++;
            if (m_data[g] !== (idx == 1 ? 32'h0200FDFF : idx == 2 ? 32'h0100FEFF : 32'h03FFFC00)) begin
              errs++;
              $display("FAIL bitrev_word idx%0d: got %0h", idx, m_data[g]);
            end
          end
          if (g == 0 && idx == 1) begin
            vecs++;
            if (m_data[g] !== 32'h0001FFFE) begin
              errs++;
              $display("FAIL natural_word idx1: got %0h expected 0001fffe", m_data[g]);
            end
          end
        end
        vecs++;
        if (done[g] !== (cyc == N + 3) || busy[g] !== (cyc <= N + 2)) begin
          errs++;
          $display("FAIL done_busy inst%0d cyc%0d: got done=%b busy=%b, expected %b %b",
                   g, cyc, done[g], busy[g], (cyc == N + 3), (cyc <= N + 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int got[2], outst[2], dcnt[2];
    logic stall[2];
    logic [DW-1:0] pd[2];
    logic [AW-1:0] pi[2];
    logic pl[2], pop;
    int cyc;
    for (int g = 0; g < 2; g++) begin got[g] = 0; outst[g] = 0; dcnt[g] = 0; stall[g] = 1'b0; end
    fft_ok = 1'b1;
    cyc = 0;
    while (!(dcnt[0] > 0 && dcnt[1] > 0) && cyc < 6000) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      if (cyc == 5) fft_ok = 1'b0;
      #1;
      cyc++;
      for (int g = 0; g < 2; g++) begin
        pop = m_valid[g] & m_ready;
        if (rd_en[g]) begin
          vecs++;
          if (outst[g] - int'(pop) >= 2) begin
            errs++;
            $display("FAIL read_overrun inst%0d: got outstanding=%0d pop=%b, required <2", g, outst[g], pop);
          end
        end
        if (stall[g]) begin
          vecs++;
          if (m_valid[g] !== 1'b1 || m_data[g] !== pd[g] || m_index[g] !== pi[g] || m_last[g] !== pl[g]) begin
            errs++;
            $display("FAIL stall_stable inst%0d: got v=%b idx=%0d data=%0h, expected 1 %0d %0h",
                     g, m_valid[g], m_index[g], m_data[g], pi[g], pd[g]);
          end
        end
        if (pop) begin
          vecs++;
          if (m_index[g] !== AW'(got[g]) || m_data[g] !== expw(g, got[g]) || m_last[g] !== (got[g] == N - 1)) begin
            errs++;
            $display("FAIL bp_beat inst%0d: got idx=%0d data=%0h, expected idx=%0d data=%0h",
                     g, m_index[g], m_data[g], got[g], expw(g, got[g]));
          end
          got[g]++;
        end
        if (done[g]) dcnt[g]++;
        outst[g] += int'(rd_en[g]) - int'(pop);
        stall[g] = m_valid[g] & ~m_ready;
        pd[g] = m_data[g]; pi[g] = m_index[g]; pl[g] = m_last[g];
      end
    end
    m_ready = 1'b1;
    repeat (5) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        if (done[g]) dcnt[g]++;
        if (m_valid[g]) got[g]++;
      end
    end
    for (int g = 0; g < 2; g++) begin
      vecs++;
      if (got[g] != N || dcnt[g] != 1 || busy[g] !== 1'b0) begin
        errs++;
        $display("FAIL bp_totals inst%0d: got beats=%0d dones=%0d busy=%b, expected %0d 1 0", g, got[g], dcnt[g], busy[g], N);
      end
    end
  endtask

  task automatic test_retrigger();
    int nb[2], dcnt[2];
    for (int g = 0; g < 2; g++) begin nb[g] = 0; dcnt[g] = 0; end
    fft_ok = 1'b1; m_ready = 1'b1;
    for (int cyc = 1; cyc <= 1060; cyc++) begin
      @(negedge clk);
      if (cyc == 5) fft_ok = 1'b0;
      if (nb[0] == 300) fft_ok = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
        if (m_valid[g]) begin
          vecs++;
          if (m_index[g] !== AW'(nb[g]) || m_data[g] !== expw(g, nb[g])) begin
            errs++;
            $display("FAIL retrig_beat inst%0d: got idx=%0d data=%0h, expected idx=%0d data=%0h",
                     g, m_index[g], m_data[g], nb[g], expw(g, nb[g]));
          end
          nb[g]++;
        end
        if (done[g]) dcnt[g]++;
      end
    end
    for (int g = 0; g < 2; g++) begin
      vecs++;
      if (nb[g] != N || dcnt[g] != 1 || busy[g] !== 1'b0) begin
        errs++;
        $display("FAIL retrig_totals inst%0d: got beats=%0d dones=%0d busy=%b, expected %0d 1 0", g, nb[g], dcnt[g], busy[g], N);
      end
    end
    fft_ok = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int nb[2], dcnt[2], cyc;
    fft_ok = 1'b1; m_ready = 1'b1;
    cyc = 0;
    while (!(m_valid[0] && m_index[0] == AW'(500)) && cyc < 600) begin tick(); cyc++; end
    vecs++;
    if (cyc >= 600) begin
      errs++;
      $display("FAIL reach_beat500: got no beat 500 within %0d cycles, required one", cyc);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      vecs++;
      if ({rd_en[g], m_valid[g], m_last[g], busy[g], done[g]} !== 5'b0 ||
          addr[g] !== '0 || m_data[g] !== '0 || m_index[g] !== '0) begin
        errs++;
        $display("FAIL midreset_outputs inst%0d: got rd=%b v=%b b=%b d=%b idx=%0h, expected all zero",
                 g, rd_en[g], m_valid[g], busy[g], done[g], m_index[g]);
      end
    end
    repeat (20) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        vecs++;
        if (m_valid[g] !== 1'b0 || busy[g] !== 1'b0 || rd_en[g] !== 1'b0) begin
          errs++;
          $display("FAIL after_reset_quiet inst%0d: got v=%b busy=%b rd=%b, expected 0 0 0", g, m_valid[g], busy[g], rd_en[g]);
        end
      end
    end
    fft_ok = 1'b0;
    tick();
    fft_ok = 1'b1;
    for (int g = 0; g < 2; g++) begin nb[g] = 0; dcnt[g] = 0; end
    for (int c = 1; c <= 1035; c++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        if (m_valid[g]) begin
          vecs++;
          if (m_index[g] !== AW'(nb[g]) || m_data[g] !== expw(g, nb[g])) begin
            errs++;
            $display("FAIL restart_beat inst%0d: got idx=%0d data=%0h, expected idx=%0d data=%0h",
                     g, m_index[g], m_data[g], nb[g], expw(g, nb[g]));
          end
          nb[g]++;
        end
        if (done[g]) dcnt[g]++;
      end
    end
    for (int g = 0; g < 2; g++) begin
      vecs++;
      if (nb[g] != N || dcnt[g] != 1) begin
        errs++;
        $display("FAIL restart_totals inst%0d: got beats=%0d dones=%0d, expected %0d 1", g, nb[g], dcnt[g], N);
      end
    end
    fft_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_retrigger();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
